// File: rtl/sram_arb_pkg.sv
// Shared constants for the SRAM port arbiter: FSM encoding, master IDs and default parameters.
// Combinational only; no latency or backpressure of its own.
package sram_arb_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic MST_INST = 1'b0;
  localparam logic MST_DATA = 1'b1;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LATENCY    = 1;
  localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/sram_arb_grant.sv
// Fixed-priority grant (data over fetch) with a saturating starvation counter for fetch.
// Grant is combinational from req; the counter updates only in free cycles.
module sram_arb_grant
  import sram_arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic free,
  input  logic m0_req,
  input  logic m1_req,
  output logic grant_valid,
  output logic grant_id
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve;
  logic          force_inst;

  assign force_inst  = m0_req && (starve == SW'(STARVE_MAX));
  assign grant_valid = free && (m0_req || m1_req);
  assign grant_id    = (m1_req && !force_inst) ? MST_DATA : MST_INST;

  // Counts free cycles in which fetch was waiting but lost to data.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve <= '0;
    end else if (free) begin
      if (!m0_req || grant_id == MST_INST) begin
        starve <= '0;
      end else if (starve != SW'(STARVE_MAX)) begin
        starve <= starve + SW'(1);
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between fetch (m0) and data (m1); one access in flight, data_ok LATENCY cycles after addr_ok.
// A losing or early request simply sees addr_ok=0 and holds until a free cycle grants it.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LATENCY    = DEF_LATENCY,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_wr,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_addr_ok,
  output logic                m0_data_ok,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_wr,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_addr_ok,
  output logic                m1_data_ok,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  logic [0:0]       state;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic             done;
  logic             free;
  logic             grant_valid;
  logic             grant_id;
  logic             accept;
  logic             sel_wr;
  logic [DATA_W/8-1:0] sel_wstrb;

  // The completion cycle is also free, which gives back-to-back issue at LATENCY=1.
  assign done = (state == ST_BUSY) && (cnt == CNT_W'(1));
  assign free = (state == ST_IDLE) || done;

  sram_arb_grant #(
    .STARVE_MAX(STARVE_MAX)
  ) u_grant (
    .clk        (clk),
    .reset      (reset),
    .free       (free),
    .m0_req     (m0_req),
    .m1_req     (m1_req),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  assign accept     = grant_valid && !reset;
  assign m0_addr_ok = accept && (grant_id == MST_INST);
  assign m1_addr_ok = accept && (grant_id == MST_DATA);

  assign sel_wr     = (grant_id == MST_DATA) ? m1_wr    : m0_wr;
  assign sel_wstrb  = (grant_id == MST_DATA) ? m1_wstrb : m0_wstrb;
  assign sram_en    = accept;
  assign sram_we    = (accept && sel_wr) ? sel_wstrb : '0;
  assign sram_addr  = (grant_id == MST_DATA) ? m1_addr  : m0_addr;
  assign sram_wdata = (grant_id == MST_DATA) ? m1_wdata : m0_wdata;

  assign m0_data_ok = done && !reset && (owner == MST_INST);
  assign m1_data_ok = done && !reset && (owner == MST_DATA);
  assign m0_rdata   = m0_data_ok ? sram_rdata : '0;
  assign m1_rdata   = m1_data_ok ? sram_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      owner <= MST_INST;
      cnt   <= '0;
    end else if (accept) begin
      state <= ST_BUSY;
      owner <= grant_id;
      cnt   <= CNT_W'(LATENCY);
    end else if (state == ST_BUSY) begin
      if (cnt == CNT_W'(1)) begin
        state <= ST_IDLE;
      end
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: two instances (LATENCY=1 and LATENCY=3) each with a behavioural SRAM,
// a pending-request queue per master and a response scoreboard checked every cycle.
module tb_sram_port_arbiter;

  logic clk;
  logic [1:0] rst;
  logic mem_init;

  logic [1:0][1:0]       req, wr;
  logic [1:0][1:0][3:0]  strb;
  logic [1:0][1:0][31:0] addr, wdat;
  wire  [1:0][1:0]       aok, dok;
  wire  [1:0][1:0][31:0] rdat;
  wire  [1:0]            s_en;
  wire  [1:0][3:0]       s_we;
  wire  [1:0][31:0]      s_addr, s_wdata, s_rdata;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1), .STARVE_MAX(4)) u_dut_l1 (
    .clk(clk), .reset(rst[0]),
    .m0_req(req[0][0]), .m0_wr(wr[0][0]), .m0_wstrb(strb[0][0]), .m0_addr(addr[0][0]),
    .m0_wdata(wdat[0][0]), .m0_addr_ok(aok[0][0]), .m0_data_ok(dok[0][0]), .m0_rdata(rdat[0][0]),
    .m1_req(req[0][1]), .m1_wr(wr[0][1]), .m1_wstrb(strb[0][1]), .m1_addr(addr[0][1]),
    .m1_wdata(wdat[0][1]), .m1_addr_ok(aok[0][1]), .m1_data_ok(dok[0][1]), .m1_rdata(rdat[0][1]),
    .sram_en(s_en[0]), .sram_we(s_we[0]), .sram_addr(s_addr[0]), .sram_wdata(s_wdata[0]),
    .sram_rdata(s_rdata[0])
  );

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(3), .STARVE_MAX(4)) u_dut_l3 (
    .clk(clk), .reset(rst[1]),
    .m0_req(req[1][0]), .m0_wr(wr[1][0]), .m0_wstrb(strb[1][0]), .m0_addr(addr[1][0]),
    .m0_wdata(wdat[1][0]), .m0_addr_ok(aok[1][0]), .m0_data_ok(dok[1][0]), .m0_rdata(rdat[1][0]),
    .m1_req(req[1][1]), .m1_wr(wr[1][1]), .m1_wstrb(strb[1][1]), .m1_addr(addr[1][1]),
    .m1_wdata(wdat[1][1]), .m1_addr_ok(aok[1][1]), .m1_data_ok(dok[1][1]), .m1_rdata(rdat[1][1]),
    .sram_en(s_en[1]), .sram_we(s_we[1]), .sram_addr(s_addr[1]), .sram_wdata(s_wdata[1]),
    .sram_rdata(s_rdata[1])
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int k);
    return (k == 64) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(k * 4));
  endfunction

  // Behavioural SRAMs: 256 words each, read data delayed 1 or 3 cycles.
  logic [31:0] smem [2][256];
  logic [31:0] pipe [2][3];
  assign s_rdata[0] = pipe[0][0];
  assign s_rdata[1] = pipe[1][2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_init) begin
        for (int k = 0; k < 256; k++) smem[i][k] <= init_word(k);
      end else if (s_en[i]) begin
        for (int b = 0; b < 4; b++)
          if (s_we[i][b]) smem[i][s_addr[i][9:2]][8*b +: 8] <= s_wdata[i][8*b +: 8];
      end
      pipe[i][0] <= smem[i][s_addr[i][9:2]];
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
  end

  typedef struct {
    int          k;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdat;
  } pend_t;

  typedef struct {
    int          inst;
    int          mst;
    int          due;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [3:0]  s0, s1;
    logic [31:0] a0, a1, d0, d1;
    logic [1:0]  exp_aok;
    logic        exp_en;
    logic [3:0]  exp_we;
    logic [31:0] exp_addr;
  } vec_t;

  pend_t       pend[$];
  exp_t        sb[$];
  logic [31:0] rmem [2][256];
  int          gmst[$], gcyc[$], dcyc[$];
  int          acc_cyc[2][2], dok_cyc[2][2], dcnt[2][2];
  int          cyc, n_chk, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int pfind(input int k);
    for (int j = 0; j < pend.size(); j++) if (pend[j].k == k) return j;
    return -1;
  endfunction

  function automatic int sfind(input int i);
    for (int j = 0; j < sb.size(); j++) if (sb[j].inst == i) return j;
    return -1;
  endfunction

  task automatic push_req(input int k, input logic w, input logic [3:0] s,
                          input logic [31:0] a, input logic [31:0] d);
    pend_t p;
    p.k = k; p.wr = w; p.strb = s; p.addr = a; p.wdat = d;
    pend.push_back(p);
  endtask

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      int j;
      j = pfind(k);
      req[k/2][k%2]  = (j >= 0);
      wr[k/2][k%2]   = (j >= 0) ? pend[j].wr   : 1'b0;
      strb[k/2][k%2] = (j >= 0) ? pend[j].strb : 4'h0;
      addr[k/2][k%2] = (j >= 0) ? pend[j].addr : 32'h0;
      wdat[k/2][k%2] = (j >= 0) ? pend[j].wdat : 32'h0;
    end
  endtask

  task automatic monitor();
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        chk("rst_addr_ok", 32'(aok[i]), 32'h0);
        chk("rst_data_ok", 32'(dok[i]), 32'h0);
        chk("rst_sram_en", 32'(s_en[i]), 32'h0);
        chk("rst_sram_we", 32'(s_we[i]), 32'h0);
        for (int j = sb.size() - 1; j >= 0; j--) if (sb[j].inst == i) sb.delete(j);
      end else begin
        chk("one_grant", 32'(aok[i][0] & aok[i][1]), 32'h0);
        chk("sram_en", 32'(s_en[i]), 32'(aok[i][0] | aok[i][1]));
        for (int m = 0; m < 2; m++) begin
          if (dok[i][m]) begin
            int j;
            j = sfind(i);
            if (j < 0) chk("unexpected_data_ok", 32'(dok[i][m]), 32'h0);
            else begin
              exp_t e;
              e = sb[j];
              sb.delete(j);
              chk("resp_master", 32'(m), 32'(e.mst));
              chk("resp_cycle", 32'(cyc), 32'(e.due));
              if (e.rd) chk("resp_rdata", rdat[i][m], e.data);
              if (i == 0) dcyc.push_back(cyc);
              dok_cyc[i][m] = cyc;
              dcnt[i][m]++;
            end
          end else begin
            chk("rdata_idle", rdat[i][m], 32'h0);
          end
          if (aok[i][m]) begin
            int j;
            j = pfind(i * 2 + m);
            if (j < 0) chk("spurious_addr_ok", 32'(aok[i][m]), 32'h0);
            else begin
              pend_t t;
              exp_t  e;
              t = pend[j];
              pend.delete(j);
              chk("sram_addr", s_addr[i], t.addr);
              chk("sram_we", 32'(s_we[i]), t.wr ? 32'(t.strb) : 32'h0);
              if (t.wr) chk("sram_wdata", s_wdata[i], t.wdat);
              e.inst = i; e.mst = m; e.due = cyc + ((i == 0) ? 1 : 3);
              e.rd = !t.wr; e.data = rmem[i][t.addr[9:2]];
              if (t.wr)
                for (int b = 0; b < 4; b++)
                  if (t.strb[b]) rmem[i][t.addr[9:2]][8*b +: 8] = t.wdat[8*b +: 8];
              sb.push_back(e);
              acc_cyc[i][m] = cyc;
              if (i == 0) begin gmst.push_back(m); gcyc.push_back(cyc); end
            end
          end
        end
      end
    end
  endtask

  task automatic tick_rest();
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic tick();
    @(negedge clk);
    tick_rest();
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && (pend.size() > 0 || sb.size() > 0); n++) tick();
    chk("drain_done", 32'(pend.size() + sb.size()), 32'h0);
    tick();
    tick();
  endtask

  vec_t vt[10];
  int   rel, t0, d0;

  initial begin
    clk = 1'b0; rst = 2'b11; mem_init = 1'b1;
    cyc = 0; n_chk = 0; n_err = 0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 256; k++) rmem[i][k] = init_word(k);
      for (int m = 0; m < 2; m++) begin acc_cyc[i][m] = -100; dok_cyc[i][m] = -100; dcnt[i][m] = 0; end
    end

    // Reset: request held throughout, must be accepted in the first cycle after release.
    push_req(0, 1'b0, 4'hF, 32'h0, 32'h0);
    drive();
    tick();
    mem_init = 1'b0;
    tick();
    tick();
    rst = 2'b00;
    rel = cyc;
    drain();
    if (gcyc.size() == 0) chk("first_accept_after_reset", 32'(gcyc.size()), 32'h1);
    else chk("first_accept_after_reset", 32'(gcyc[0]), 32'(rel));

    // Single-cycle arbitration vectors on the LATENCY=1 instance, from idle.
    vt[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0,  32'h100, 32'h0, 32'h0,        2'b10, 1'b1, 4'h0, 32'h100};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0,  32'h0,   32'h0, 32'h0,        2'b01, 1'b1, 4'h0, 32'h0};
    vt[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h8,  32'hC,   32'h0, 32'h0,        2'b10, 1'b1, 4'h0, 32'hC};
    vt[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h3, 32'h0,  32'h40,  32'h0, 32'h12345678, 2'b10, 1'b1, 4'h3, 32'h40};
    vt[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0,  32'h40,  32'h0, 32'h0,        2'b10, 1'b1, 4'h0, 32'h40};
    vt[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h44, 32'h0,   32'hFFFFFFFF, 32'h0, 2'b01, 1'b1, 4'h0, 32'h44};
    vt[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 32'h48, 32'h0,   32'h0, 32'h0,        2'b01, 1'b1, 4'h0, 32'h48};
    vt[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0,  32'h0,   32'h0, 32'h0,        2'b00, 1'b0, 4'h0, 32'h0};
    vt[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'hC, 4'h0, 32'h80, 32'h84,  32'hAABBCCDD, 32'h0, 2'b10, 1'b1, 4'h0, 32'h84};
    vt[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 32'h80, 32'h0,   32'h11223344, 32'h0, 2'b01, 1'b1, 4'hF, 32'h80};
    for (int v = 0; v < 10; v++) begin
      if (vt[v].r0) push_req(0, vt[v].w0, vt[v].s0, vt[v].a0, vt[v].d0);
      if (vt[v].r1) push_req(1, vt[v].w1, vt[v].s1, vt[v].a1, vt[v].d1);
      drive();
      @(negedge clk);
      chk($sformatf("vec%0d_addr_ok", v), 32'({aok[0][1], aok[0][0]}), 32'(vt[v].exp_aok));
      chk($sformatf("vec%0d_sram_en", v), 32'(s_en[0]), 32'(vt[v].exp_en));
      chk($sformatf("vec%0d_sram_we", v), 32'(s_we[0]), 32'(vt[v].exp_we));
      if (vt[v].exp_en) chk($sformatf("vec%0d_sram_addr", v), s_addr[0], vt[v].exp_addr);
      tick_rest();
      drain();
    end

    // Both masters requesting continuously: four data grants, then one forced fetch grant.
    gmst.delete(); gcyc.delete();
    for (int n = 0; n < 4; n++)  push_req(0, 1'b0, 4'h0, 32'h200 + 32'(4 * n), 32'h0);
    for (int n = 0; n < 14; n++) push_req(1, 1'b0, 4'h0, 32'h300 + 32'(4 * n), 32'h0);
    drive();
    repeat (15) tick();
    if (gmst.size() < 15) chk("starve_grant_count", 32'(gmst.size()), 32'd15);
    else begin
      for (int k = 0; k < 15; k++)
        chk($sformatf("starve_grant%0d", k), 32'(gmst[k]), (k % 5 == 4) ? 32'h0 : 32'h1);
      chk("starve_rate", 32'(gcyc[14] - gcyc[0]), 32'd14);
    end
    drain();

    // LATENCY=3: data request arriving right after a fetch accept waits for its completion.
    push_req(2, 1'b0, 4'h0, 32'h10, 32'h0);
    drive();
    tick();
    t0 = acc_cyc[1][0];
    push_req(3, 1'b0, 4'h0, 32'h14, 32'h0);
    drive();
    drain();
    chk("l3_m1_accept", 32'(acc_cyc[1][1] - t0), 32'd3);
    chk("l3_m0_done", 32'(dok_cyc[1][0] - t0), 32'd3);
    chk("l3_m1_done", 32'(dok_cyc[1][1] - t0), 32'd6);

    // Reset one cycle after a LATENCY=3 accept drops the access; held request goes first after reset.
    d0 = dcnt[1][0];
    push_req(2, 1'b0, 4'h0, 32'h20, 32'h0);
    drive();
    tick();
    chk("rst_prior_accept", 32'(acc_cyc[1][0]), 32'(cyc - 1));
    push_req(3, 1'b0, 4'h0, 32'h24, 32'h0);
    rst[1] = 1'b1;
    drive();
    tick();
    rst[1] = 1'b0;
    rel = cyc;
    repeat (8) tick();
    chk("rst_no_m0_data_ok", 32'(dcnt[1][0] - d0), 32'h0);
    chk("rst_m1_first_cycle", 32'(acc_cyc[1][1]), 32'(rel));
    drain();

    // Back-to-back fetch reads at LATENCY=1.
    gcyc.delete(); dcyc.delete();
    push_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
    push_req(0, 1'b0, 4'h0, 32'h4, 32'h0);
    push_req(0, 1'b0, 4'h0, 32'h8, 32'h0);
    drive();
    drain();
    if (gcyc.size() < 3 || dcyc.size() < 3) chk("b2b_count", 32'(gcyc.size() + dcyc.size()), 32'd6);
    else begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("b2b_accept%0d", k), 32'(gcyc[k] - gcyc[0]), 32'(k));
        chk($sformatf("b2b_done%0d", k), 32'(dcyc[k] - gcyc[0]), 32'(k + 1));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port synchronous SRAM between the instruction-fetch requester (m0) and the data-access requester from the execute stage (m1). Each side uses a req/addr_ok/data_ok handshake with at most one transaction in flight across both masters. Data has fixed priority, and a starvation guard bounds fetch stalls. The block sits between the pre-IF/EXE stages and the SRAM macro.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- LATENCY, 1, cycles from accept to read data valid; must be ≥1
- STARVE_MAX, 4, consecutive denied m0 request cycles before m0 is forced a grant; must be ≥1
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- mN_req  in  1  request valid; N = 0 (inst), 1 (data)
- mN_wr  in  1  1 = write, 0 = read
- mN_wstrb  in  DATA_W/8  byte write enables; ignored on reads
- mN_addr  in  ADDR_W  byte address
- mN_wdata  in  DATA_W  write data
- mN_addr_ok  out  1  request accepted this cycle
- mN_data_ok  out  1  one-cycle completion pulse
- mN_rdata  out  DATA_W  read data; valid only with mN_data_ok
- sram_en  out  1  SRAM access enable
- sram_we  out  DATA_W/8  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data; valid LATENCY cycles after the enabled cycle

## Operation
- FSM states:
  - IDLE: nothing in flight.
  - BUSY: in flight. Holds `owner` (0/1) and `cnt`.
- free = (state==IDLE) || (state==BUSY && cnt==1).
- Grant is computed only when free:
  - m1 wins whenever m1_req, unless starve==STARVE_MAX and m0_req, in which case m0 wins.
  - Otherwise m0 wins if m0_req.
- Accept cycle:
  - The granted master's addr_ok=1, combinational from req.
  - Same cycle: sram_en=1, sram_addr/sram_wdata from the granted master, and sram_we = wr ? wstrb : 0.
  - No other cycle drives sram_en=1.
- Next state:
  - After an accept: BUSY, owner=grant, cnt=LATENCY.
  - BUSY with cnt>1: cnt decrements.
  - BUSY with cnt==1 and no accept: IDLE.
- Completion:
  - When state==BUSY && cnt==1, mowner_data_ok=1 and mowner_rdata = sram_rdata, passed through combinationally.
  - Writes complete the same way; their rdata is don't-care.
- Back-to-back: a new accept may occur in the completion cycle. The response and the new request can belong to different masters.
- Starvation counter `starve`, saturating at STARVE_MAX:
  - Increments each free cycle in which m0_req=1 and m1 wins.
  - Clears when m0 is granted or m0_req=0.
  - Holds when not free.
- Requests are level-sensitive. A master holds req and payload until addr_ok. Changing the payload before addr_ok is legal, and the sampled value is the one present in the accept cycle.
- Width rules:
  - No address translation and no alignment check; addresses pass through unchanged.
  - mN_wstrb==0 on a write issues a no-op write and still returns data_ok.

## Timing
- Reset (sync): state=IDLE, cnt=0, starve=0.
  - While reset=1, all addr_ok, data_ok, sram_en, sram_we are forced 0.
  - rdata outputs are 0 unless data_ok.
- Reset mid-transaction drops the outstanding access. No data_ok is ever issued for it.
- Latency: accept at cycle T gives data_ok at T+LATENCY.
- Sustained throughput is 1 transaction/cycle at any LATENCY=1. Otherwise it is 1 per LATENCY cycles.
- Both masters requesting in the same free cycle: exactly one addr_ok. The loser sees addr_ok=0 and keeps waiting.
- A request arriving while not free is not accepted. It is accepted in the first later free cycle in which it wins arbitration.

## Structure
- Shared package `sram_arb_pkg`:
  - FSM state encoding (IDLE, BUSY).
  - Master ID constants MST_INST=0, MST_DATA=1.
  - Default parameter values.
- One sub-module, `sram_arb_grant`: combinational priority plus the starvation counter register. It takes free and both req bits, and outputs grant_valid and grant_id.
- Top level holds the FSM, the latency counter, the SRAM mux and the response demux.

## Test plan
- LATENCY=1, m1 read 0x100 alone (SRAM holds 0xDEADBEEF): m1_addr_ok at T, sram_en=1 with sram_addr=0x100, m1_data_ok at T+1 with rdata 0xDEADBEEF. m0 outputs stay 0.
- Both req continuously, STARVE_MAX=4, LATENCY=1: grants are m1,m1,m1,m1,m0, repeating. m0 data_ok appears every 5th cycle.
- m1 write addr 0x40, wstrb 4'b0011, wdata 0x12345678: sram_we=4'b0011 in the accept cycle, m1_data_ok one cycle later. A following read of 0x40 returns the updated low half.
- LATENCY=3, m0 read then immediate m1 read: m1_addr_ok is withheld until the cycle m0_data_ok fires (T+3). m1_data_ok at T+6.
- Reset asserted the cycle after a LATENCY=3 accept: no data_ok ever fires. After reset deasserts, the first request is accepted in its first cycle.
- Back-to-back m0 reads 0x0, 0x4, 0x8 at LATENCY=1: addr_ok on 3 consecutive cycles, then data_ok on the next 3 consecutive cycles in order.
